// File: rtl/aes256_ctr_sequencer.sv
// rtl/aes256_ctr_sequencer.sv - AES-256-CTR top-level sequencer
//
// Purpose:
//   Takes the key and IV. Starts key expansion and waits for it to finish.
//   Then, for each plaintext block, it issues the current counter block to
//   the AES-256 block core and XORs the returned keystream with the plaintext.
//   Each wait on an engine is guarded by a watchdog.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   key_load, key, iv            strobe capturing cipher key and initial counter block
//   ke_start, ke_key, ke_done    key-expansion engine handshake
//   core_start, core_block       block-encrypt request (counter block)
//   core_done, core_result       block-encrypt response (keystream)
//   in_valid/in_ready/in_data/in_last      plaintext stream
//   out_valid/out_ready/out_data/out_last  ciphertext stream
//   key_ready                    expanded key valid
//   ctr_wrap, err_timeout        sticky status flags
module aes256_ctr_sequencer #(
  parameter int CTR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [255:0] key,
  input  logic [127:0] iv,
  output logic         ke_start,
  output logic [255:0] ke_key,
  input  logic         ke_done,
  output logic         core_start,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_result,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         key_ready,
  output logic         ctr_wrap,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY_EXP = 3'd1,
    READY   = 3'd2,
    ENCRYPT = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  // The watchdog only needs to count up to TIMEOUT_CYCLES-1. It leaves the
  // wait state on that count, so it never overflows.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Mask of the incrementing counter field. This also holds for CTR_WIDTH == 128:
  // the shift yields 0, and subtracting 1 gives all ones.
  localparam logic [127:0] LOW_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

  state_t            state;
  state_t            state_next;
  logic [127:0]      ctr;
  logic [127:0]      iv_reg;
  logic [127:0]      data_reg;
  logic              last_reg;
  logic [WD_W-1:0]   wdog;

  logic              key_cap;
  logic              blk_acc;
  logic              ke_hit;
  logic              core_hit;
  logic              wd_expired;
  logic              out_hs;
  logic              in_wait;
  logic [127:0]      ctr_inc;
  logic              ctr_at_max;

  always_comb begin
    key_cap    = key_load && ((state == IDLE) || (state == READY));
    // key_load wins over a simultaneous plaintext handshake in READY
    blk_acc    = (state == READY) && !key_load && in_valid;
    ke_hit     = (state == KEY_EXP) && ke_done;
    core_hit   = (state == ENCRYPT) && core_done;
    out_hs     = (state == OUTPUT) && out_ready;
    wd_expired = (wdog == WD_LAST);
    in_wait    = (state == KEY_EXP) || (state == ENCRYPT);
    ctr_at_max = ((ctr & LOW_MASK) == LOW_MASK);
    ctr_inc    = (ctr & ~LOW_MASK) | ((ctr + 128'd1) & LOW_MASK);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (key_cap) state_next = KEY_EXP;
      end
      KEY_EXP: begin
        if (ke_done)         state_next = READY;
        else if (wd_expired) state_next = IDLE;
      end
      READY: begin
        if (key_cap)      state_next = KEY_EXP;
        else if (blk_acc) state_next = ENCRYPT;
      end
      ENCRYPT: begin
        if (core_done)       state_next = OUTPUT;
        else if (wd_expired) state_next = IDLE;
      end
      OUTPUT: begin
        if (out_ready) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The start pulses come from the watchdog. It reads zero only in the first
  // cycle of each wait state, because it is cleared whenever a wait state is
  // entered or left.
  assign ke_start   = (state == KEY_EXP) && (wdog == '0);
  assign core_start = (state == ENCRYPT) && (wdog == '0);
  assign core_block = ctr;
  assign in_ready   = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      ke_key      <= '0;
      ctr         <= '0;
      iv_reg      <= '0;
      data_reg    <= '0;
      last_reg    <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      key_ready   <= 1'b0;
      ctr_wrap    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (in_wait && (state_next == state)) wdog <= wdog + WD_W'(1);
      else                                  wdog <= '0;

      if (key_cap) begin
        ke_key      <= key;
        ctr         <= iv;
        iv_reg      <= iv;
        key_ready   <= 1'b0;
        ctr_wrap    <= 1'b0;
        err_timeout <= 1'b0;
      end

      if (ke_hit) begin
        key_ready <= 1'b1;
      end else if ((state == KEY_EXP) && wd_expired) begin
        err_timeout <= 1'b1;
        key_ready   <= 1'b0;
      end

      if (blk_acc) begin
        data_reg <= in_data;
        last_reg <= in_last;
      end

      if (core_hit) begin
        out_data  <= data_reg ^ core_result;
        out_last  <= last_reg;
        out_valid <= 1'b1;
        ctr       <= ctr_inc;
        if (ctr_at_max) ctr_wrap <= 1'b1;
      end else if ((state == ENCRYPT) && wd_expired) begin
        err_timeout <= 1'b1;
        key_ready   <= 1'b0;
        out_valid   <= 1'b0;
      end

      // After the final block of a message, the next message restarts from the IV.
      if (out_hs) begin
        out_valid <= 1'b0;
        if (out_last) ctr <= iv_reg;
      end
    end
  end

endmodule

// File: tb/tb_aes256_ctr_sequencer.sv
// tb/tb_aes256_ctr_sequencer.sv - randomized self-checking bench for aes256_ctr_sequencer
module tb_aes256_ctr_sequencer;

  localparam int TMO = 16;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [255:0] key;
  logic [127:0] iv;
  logic         ke_start;
  logic [255:0] ke_key;
  logic         ke_done;
  logic         core_start;
  logic [127:0] core_block;
  logic         core_done;
  logic [127:0] core_result;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         key_ready;
  logic         ctr_wrap;
  logic         err_timeout;

  always #5 clk = ~clk;

  aes256_ctr_sequencer #(.CTR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .iv(iv),
    .ke_start(ke_start), .ke_key(ke_key), .ke_done(ke_done),
    .core_start(core_start), .core_block(core_block),
    .core_done(core_done), .core_result(core_result),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .key_ready(key_ready), .ctr_wrap(ctr_wrap), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the counter block is nonce(96) || count(32). The count
  // advances modulo 2^32 for each encrypted block and restarts from the IV
  // after a last block.
  logic [127:0] m_ctr;
  logic [127:0] m_iv;
  logic         m_wrap;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] all_outs_zero_vec();
    return {248'd0, ke_start, core_start, in_ready, out_valid, out_last,
            key_ready, ctr_wrap, err_timeout};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, all_outs_zero_vec(), 256'd0);
    chk({tag, "_out_data"}, {128'd0, out_data}, 256'd0);
    chk({tag, "_core_block"}, {128'd0, core_block}, 256'd0);
    chk({tag, "_ke_key"}, ke_key, 256'd0);
  endtask

  task automatic load_key(input logic [255:0] k, input logic [127:0] v, input int lat);
    int pulses;
    key = k;
    iv = v;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    key = rand128();
    iv = rand128();
    m_ctr = v;
    m_iv = v;
    m_wrap = 1'b0;
    pulses = 0;
    for (int c = 0; c <= lat; c++) begin
      if (ke_start) pulses++;
      if (c == lat) ke_done = 1'b1;
      tick();
      ke_done = 1'b0;
    end
    if (ke_start) pulses++;
    chk("ke_start_pulses", 256'(pulses), 256'd1);
    chk("key_ready", 256'(key_ready), 256'd1);
    chk("in_ready_after_ke", 256'(in_ready), 256'd1);
    chk("ke_key", ke_key, k);
    chk("flags_cleared", {254'd0, ctr_wrap, err_timeout}, 256'd0);
  endtask

  task automatic send_block(input logic [127:0] pt, input logic last, input int lat, input int bp);
    int waits;
    int starts;
    logic [127:0] exp_blk;
    logic [127:0] blk;
    logic [127:0] held;
    waits = 0;
    while (!in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 256'(in_ready), 256'd1);
      return;
    end
    in_valid = 1'b1;
    in_data = pt;
    in_last = last;
    tick();
    in_valid = 1'b0;
    in_data = rand128();
    in_last = 1'b0;
    exp_blk = m_ctr;
    chk("core_start", 256'(core_start), 256'd1);
    chk("core_block", {128'd0, core_block}, {128'd0, exp_blk});
    chk("in_ready_enc", 256'(in_ready), 256'd0);
    blk = core_block;
    starts = 0;
    for (int c = 0; c <= lat; c++) begin
      if (core_start) starts++;
      if (c == lat) begin
        core_done = 1'b1;
        core_result = blk ^ ONES;
      end
      tick();
      core_done = 1'b0;
      core_result = rand128();
    end
    chk("core_start_pulses", 256'(starts), 256'd1);
    if (m_ctr[31:0] == 32'hFFFF_FFFF) m_wrap = 1'b1;
    m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
    chk("out_valid", 256'(out_valid), 256'd1);
    chk("out_data", {128'd0, out_data}, {128'd0, pt ^ ~exp_blk});
    chk("out_last", 256'(out_last), 256'(last));
    chk("ctr_wrap", 256'(ctr_wrap), 256'(m_wrap));
    held = out_data;
    for (int c = 0; c < bp; c++) tick();
    if (bp > 0) begin
      chk("bp_out_data", {128'd0, out_data}, {128'd0, held});
      chk("bp_out_valid", 256'(out_valid), 256'd1);
      chk("bp_in_ready", 256'(in_ready), 256'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 256'(out_valid), 256'd0);
    chk("in_ready_back", 256'(in_ready), 256'd1);
    if (last) m_ctr = m_iv;
  endtask

  initial begin
    logic [127:0] v;
    rst = 1'b1;
    key_load = 1'b0;
    key = '0;
    iv = '0;
    ke_done = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    m_ctr = '0;
    m_iv = '0;
    m_wrap = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Directed block sequence from a known IV
    load_key({rand128(), rand128()}, 128'h000102030405060708090A0B00000005, 10);
    for (int i = 0; i < 3; i++) send_block('0, 1'b0, 14, 0);

    // Counter wrap
    load_key({rand128(), rand128()}, 128'h000102030405060708090A0BFFFFFFFE, 3);
    for (int i = 0; i < 3; i++) send_block(rand128(), 1'b0, 5, 0);

    // Backpressure, then a last block, then the counter restarts from the IV
    send_block(rand128(), 1'b0, 2, 20);
    send_block(rand128(), 1'b1, 2, 0);
    send_block(rand128(), 1'b0, 2, 0);

    // Timeout: the core never answers
    in_valid = 1'b1;
    in_data = rand128();
    tick();
    in_valid = 1'b0;
    chk("tmo_core_start", 256'(core_start), 256'd1);
    for (int c = 1; c <= TMO; c++) begin
      tick();
      if (c == TMO - 1) chk("tmo_early", 256'(err_timeout), 256'd0);
    end
    chk("tmo_err", 256'(err_timeout), 256'd1);
    chk("tmo_key_ready", 256'(key_ready), 256'd0);
    chk("tmo_out_valid", 256'(out_valid), 256'd0);
    chk("tmo_idle_in_ready", 256'(in_ready), 256'd0);
    tick();
    chk("tmo_no_restart", 256'(core_start), 256'd0);

    // Reset in the middle of ENCRYPT
    load_key({rand128(), rand128()}, rand128(), 4);
    in_valid = 1'b1;
    in_data = rand128();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_mid");
    core_done = 1'b1;
    core_result = rand128();
    tick();
    core_done = 1'b0;
    check_all_zero("rst_late_done");
    tick();
    chk("rst_no_out_valid", 256'(out_valid), 256'd0);

    // Randomized sessions, some of them close to the counter wrap
    for (int s = 0; s < 6; s++) begin
      v = rand128();
      if ($urandom_range(0, 1) == 1) v[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      load_key({rand128(), rand128()}, v, $urandom_range(0, 14));
      for (int b = 0; b < 5; b++) begin
        send_block(rand128(), ($urandom_range(0, 3) == 0), $urandom_range(0, 14),
                   $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
